// File: rtl/mdu_pkg.sv
// Shared op codes, latency defaults and counter sizing for the E-stage multiply/divide unit.
package mdu_pkg;

   localparam int unsigned MD_OP_W = 4;

   localparam logic [MD_OP_W-1:0] OP_NONE  = 4'd0;
   localparam logic [MD_OP_W-1:0] OP_MULT  = 4'd1;
   localparam logic [MD_OP_W-1:0] OP_MULTU = 4'd2;
   localparam logic [MD_OP_W-1:0] OP_DIV   = 4'd3;
   localparam logic [MD_OP_W-1:0] OP_DIVU  = 4'd4;
   localparam logic [MD_OP_W-1:0] OP_MTHI  = 4'd5;
   localparam logic [MD_OP_W-1:0] OP_MTLO  = 4'd6;
   localparam logic [MD_OP_W-1:0] OP_MFHI  = 4'd7;
   localparam logic [MD_OP_W-1:0] OP_MFLO  = 4'd8;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;
   localparam int unsigned CNT_W           = $clog2(DIV_CYCLES_DEF + 1);

   function automatic logic is_muldiv(input logic [MD_OP_W-1:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_mult(input logic [MD_OP_W-1:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational multiply/divide datapath: returns {hi, lo} for the op and flags a zero divisor.
module mdu_core
   import mdu_pkg::*;
(
   input  logic [MD_OP_W-1:0] op,
   input  logic [31:0]        rs,
   input  logic [31:0]        rt,
   output logic [63:0]        res,
   output logic               div_zero
);

   logic        neg_a;
   logic        neg_b;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] quo;
   logic [31:0] rem;

   // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
   assign neg_a = (op == OP_DIV) & rs[31];
   assign neg_b = (op == OP_DIV) & rt[31];
   assign div_a = neg_a ? -rs : rs;
   assign div_b = (rt == '0) ? 32'd1 : (neg_b ? -rt : rt);
   assign quo   = div_a / div_b;
   assign rem   = div_a % div_b;

   always_comb begin
      res      = '0;
      div_zero = 1'b0;
      case (op)
         OP_MULT:  res = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
         OP_MULTU: res = {32'd0, rs} * {32'd0, rt};
         OP_DIV, OP_DIVU: begin
            div_zero   = (rt == '0);
            res[31:0]  = (neg_a ^ neg_b) ? -quo : quo;
            res[63:32] = neg_a ? -rem : rem;
         end
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO registers, emulated multi-cycle latency and stall request.
module e_mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [MD_OP_W-1:0] md_op,
   input  logic [31:0]        rs_data,
   input  logic [31:0]        rt_data,
   output logic               busy,
   output logic [31:0]        md_rd
);

   logic [31:0]      hi;
   logic [31:0]      lo;
   logic [31:0]      hi_nx;
   logic [31:0]      lo_nx;
   logic [CNT_W-1:0] cnt;
   logic [63:0]      core_res;
   logic             div_zero;
   logic             idle;
   logic             issue;

   mdu_core u_core (
      .op       (md_op),
      .rs       (rs_data),
      .rt       (rt_data),
      .res      (core_res),
      .div_zero (div_zero)
   );

   assign idle  = (cnt == '0);
   assign issue = start & is_muldiv(md_op);
   assign busy  = reset & (issue | ~idle);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi    <= '0;
         lo    <= '0;
         hi_nx <= '0;
         lo_nx <= '0;
         cnt   <= '0;
      end else if (!idle) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            hi <= hi_nx;
            lo <= lo_nx;
         end
      end else if (start) begin
         if (is_muldiv(md_op)) begin
            cnt <= is_mult(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            // A zero divisor re-commits the current HI/LO so completion is a no-op.
            hi_nx <= div_zero ? hi : core_res[63:32];
            lo_nx <= div_zero ? lo : core_res[31:0];
         end else if (md_op == OP_MTHI) begin
            hi <= rs_data;
         end else if (md_op == OP_MTLO) begin
            lo <= rs_data;
         end
      end
   end

   always_comb begin
      md_rd = '0;
      if (start && md_op == OP_MFHI) md_rd = hi;
      else if (start && md_op == OP_MFLO) md_rd = lo;
   end

   start_while_busy: assert property (@(posedge clk) disable iff (!reset) !(start && !idle))
      else $error("e_mdu: start asserted while the unit is busy");

endmodule

// File: tb/tb_e_mdu.sv
// Randomized and directed bench for e_mdu against a plain-arithmetic HI/LO model.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  md_op = 4'd0;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        busy;
   logic [31:0] md_rd;

   int total = 0;
   int bad = 0;

   // model state
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [31:0] p_hi = '0;
   logic [31:0] p_lo = '0;
   bit          p_dz = 1'b0;
   bit          pend = 1'b0;
   int          p_done = 0;
   int          cyc = 0;

   logic        exp_b;
   logic [31:0] exp_rd;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .md_op   (md_op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .busy    (busy),
      .md_rd   (md_rd)
   );

   always #5 clk = ~clk;

   function automatic void calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output bit dz);
      longint sa, sb, p, q, r;
      longint unsigned pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      h = '0; l = '0; dz = 1'b0;
      case (op)
         4'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
         4'd2: begin pu = {32'd0, a} * {32'd0, b}; h = pu[63:32]; l = pu[31:0]; end
         4'd3: if (b == 0) dz = 1'b1;
               else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
         4'd4: if (b == 0) dz = 1'b1;
               else begin l = a / b; h = a % b; end
         default: ;
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_hi = '0; m_lo = '0; pend = 1'b0; cyc = 0;
      end else begin
         if (pend) begin
            if (cyc == p_done) begin
               if (!p_dz) begin m_hi = p_hi; m_lo = p_lo; end
               pend = 1'b0;
            end
         end else if (start) begin
            case (md_op)
               4'd1, 4'd2, 4'd3, 4'd4: begin
                  calc(md_op, rs_data, rt_data, p_hi, p_lo, p_dz);
                  pend = 1'b1;
                  p_done = cyc + ((md_op <= 4'd2) ? 5 : 10);
               end
               4'd5: m_hi = rs_data;
               4'd6: m_lo = rs_data;
               default: ;
            endcase
         end
         cyc++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #1;
      start = st; md_op = op; rs_data = a; rt_data = b;
   endtask

   task automatic idle();
      drive(1'b0, 4'($urandom), $urandom, $urandom);
   endtask

   task automatic rd(input logic [3:0] op, input logic [31:0] exp, input string nm);
      drive(1'b1, op, $urandom, $urandom);
      #1 chk(nm, md_rd, exp);
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_len, input string nm);
      int n;
      drive(1'b1, op, a, b);
      #1;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (!busy) break;
         n++;
         idle();
         #1;
      end
      chk(nm, n, exp_len);
   endtask

   task automatic wait_idle(input string nm);
      int k;
      for (k = 0; k < 40; k++) begin
         if (!busy) break;
         idle();
         #1;
      end
      if (k == 40) chk(nm, busy, 1'b0);
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         4: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      fork
         forever begin
            @(negedge clk);
            exp_b  = reset && (pend || (start && md_op inside {4'd1, 4'd2, 4'd3, 4'd4}));
            exp_rd = (start && md_op == 4'd7) ? m_hi : (start && md_op == 4'd8) ? m_lo : 32'd0;
            chk("cycle_busy", busy, exp_b);
            chk("cycle_md_rd", md_rd, exp_rd);
         end
      join_none

      repeat (2) @(posedge clk);
      #3 reset = 1'b1;

      rd(4'd7, 32'h0, "reset_hi");
      rd(4'd8, 32'h0, "reset_lo");

      run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 6, "mult_busy_len");
      rd(4'd7, 32'hFFFF_FFFF, "mult_hi");
      rd(4'd8, 32'hFFFF_FFFA, "mult_lo");

      run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 6, "multu_busy_len");
      rd(4'd7, 32'h0000_0002, "multu_hi");
      rd(4'd8, 32'hFFFF_FFFA, "multu_lo");

      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 11, "div_busy_len");
      rd(4'd7, 32'hFFFF_FFFF, "div_hi");
      rd(4'd8, 32'hFFFF_FFFD, "div_lo");

      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 11, "div_ovf_busy_len");
      rd(4'd7, 32'h0, "div_ovf_hi");
      rd(4'd8, 32'h8000_0000, "div_ovf_lo");

      drive(1'b1, 4'd5, 32'h11, $urandom);
      rd(4'd7, 32'h11, "mthi_next_cycle");
      drive(1'b1, 4'd6, 32'h22, $urandom);
      run_op(4'd4, 32'd5, 32'd0, 11, "divu_zero_busy_len");
      rd(4'd7, 32'h11, "divu_zero_hi_kept");
      rd(4'd8, 32'h22, "divu_zero_lo_kept");

      // back-to-back: divu issues in the first cycle after the mult's countdown ends
      drive(1'b1, 4'd1, 32'd7, 32'd6);
      repeat (5) idle();
      drive(1'b1, 4'd4, 32'd100, 32'd7);
      #1 chk("b2b_issue_busy", busy, 1'b1);
      wait_idle("b2b_timeout");
      rd(4'd8, 32'd14, "b2b_lo");
      rd(4'd7, 32'd2, "b2b_hi");

      // reset in the middle of a divide
      drive(1'b1, 4'd3, 32'd1000, 32'd3);
      repeat (3) idle();
      #2 reset = 1'b0;
      #1 chk("reset_mid_div_busy", busy, 1'b0);
      @(posedge clk);
      #3 reset = 1'b1;
      rd(4'd7, 32'h0, "reset_mid_div_hi");
      rd(4'd8, 32'h0, "reset_mid_div_lo");

      repeat (600) begin
         @(posedge clk);
         #1;
         if (!pend && $urandom_range(0, 2) != 0) begin
            start = 1'b1;
            md_op = 4'($urandom_range(0, 15));
         end else begin
            start = 1'b0;
            md_op = 4'($urandom);
         end
         rs_data = rand_val();
         rt_data = rand_val();
      end
      wait_idle("final_timeout");
      drive(1'b0, 4'd0, '0, '0);
      @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit of the 5-stage MIPS pipeline. Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E stage and holds HI/LO. Emulates multi-cycle latency with a countdown counter. Produces `busy`, which the hazard stall unit ANDs with "D-stage instruction is an MD op" to freeze F/D and bubble E.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles after a mult/multu issue cycle.
- `DIV_CYCLES`, 10: busy cycles after a div/divu issue cycle.

Ports:
- `clk`  in  1  the single pipeline clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  E-stage instruction is a valid MD op (not a bubble).
- `md_op`  in  4  op code from `mdu_pkg`; ignored when `start`=0.
- `rs_data`  in  32  forwarded rs operand.
- `rt_data`  in  32  forwarded rt operand.
- `busy`  out  1  unit occupied; goes to the stall unit.
- `md_rd`  out  32  mfhi/mflo result, merged into the E-stage result mux.

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8. Codes 9–15 are treated as NONE.
- State:
  - `hi` and `lo`: 32-bit registers.
  - `cnt`: 4-bit countdown counter.
  - `hi_nx` and `lo_nx`: 32-bit pending results.
- Issue condition: an issue of MULT/MULTU/DIV/DIVU happens when `start`=1, `cnt`=0 and the op is one of those four.
  - Compute the 64-bit result and store it in `hi_nx`/`lo_nx`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
- MULT: signed 32×32→64; hi=[63:32], lo=[31:0]. MULTU: unsigned 32×32→64.
- DIV: lo = signed quotient, truncated toward zero; hi = remainder, which takes the sign of the dividend (rs).
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt=0): the full DIV_CYCLES latency still elapses, and hi/lo keep their previous values.
- Countdown: while `cnt`≠0, `cnt` decrements every edge. On the edge where `cnt`=1, hi←`hi_nx` and lo←`lo_nx`.
- MTHI/MTLO: with `start`=1 and `cnt`=0, hi (or lo) ← rs_data at the edge.
- MFHI/MFLO: `md_rd` is combinational; it is hi for MFHI, lo for MFLO, and 0 for all other ops.
- `busy` = (`start` & op ∈ {MULT, MULTU, DIV, DIVU}) | (`cnt`≠0).
- Any `start` while `cnt`≠0 is a protocol violation: it is ignored, with no state change, and flagged by a simulation assertion.

## Timing
- Reset: when `reset`=0, immediately hi=0, lo=0, cnt=0, hi_nx=0, lo_nx=0. Then `busy`=0, and `md_rd`=0 unless `start`&MFHI/MFLO.
- Reset mid-operation aborts the operation. The pending result is discarded, and `busy` drops in the same cycle as reset assertion.
- Mult issued in cycle T:
  - `busy`=1 in cycles T..T+5 (6 cycles).
  - hi/lo are updated at the end of T+5.
  - MFHI in E at T+6 returns the new value.
- Div issued in cycle T: `busy` is high for T..T+10, and hi/lo are updated at the end of T+10.
- `busy` depends combinationally on `start` in the issue cycle. A D-stage MD op directly behind an issuing mult/div therefore stalls immediately.
- MTHI/MTLO in cycle T: an MFHI/MFLO in E at T+1 sees the new value. There is no busy assertion.
- Back-to-back: a new mult/div can issue in the first cycle with `cnt`=0, i.e. T+6 after a mult. The completion edge and the new issue never coincide.

## Structure
- `mdu_pkg`: op-code localparams, `MD_OP_W`=4, default latency constants, and a `cnt` width wide enough for the maximum latency.
- Sub-module `mdu_core`: purely combinational. Inputs: op, rs, rt. Outputs: 64-bit {hi, lo} plus a `div_zero` flag. Holds all signed/unsigned arithmetic.
- `e_mdu` holds the registers, the counter, the busy logic and the read mux.

## Test plan
- Reset: assert `reset`=0 mid-div → `busy`=0 at once; after release, MFHI and MFLO both return 0.
- MULT rs=0xFFFFFFFE (−2), rt=3 → `busy` high for exactly 6 cycles; then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=−7 (0xFFFFFFF9), rt=2 → `busy` for 11 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload hi=0x11 and lo=0x22 via MTHI/MTLO; then DIVU rs=5, rt=0 → `busy` for 11 cycles, after which hi=0x11 and lo=0x22 are unchanged.
- MFLO issued in E during cycle T+3 of a mult → assertion fires, and hi/lo end with the mult result only. A legal MFLO at T+6 returns the new lo.
